rc_req_sched: RTL and testbench
===============================

Name: rc_req_sched

Overview:
Request-buffer scheduler for the ring controller. Holds up to NUM_ENTRIES outstanding core requests and drives the external age-ordering matrix: allocation, deallocation and the two class masks. It issues the oldest eligible entry to the ring through a registered valid/ready port. Read responses take strict priority over all other commands, and age order is kept within each class.

Parameters:
NUM_ENTRIES, 4, buffer depth; also the width of the age-matrix vectors.
ADDR_W, 32, address width.
DATA_W, 32, data width.
TAG_W, $clog2(NUM_ENTRIES), entry index width (derived; not overridden).

Ports:
Clk  in  1  single clock, rising edge.
Rst  in  1  asynchronous, active-low reset.
InReqValid  in  1  core request valid.
InReqReady  out  1  buffer can accept a request this cycle.
InReqOpcode  in  2  0=RD, 1=WR, 2=RD_RSP; 3 is illegal.
InReqAddr  in  ADDR_W  request address.
InReqData  in  DATA_W  request data.
OutReqValid  out  1  issued request valid (registered).
OutReqReady  in  1  ring accepts the issued request.
OutReqOpcode  out  2  opcode of the issued entry.
OutReqAddr  out  ADDR_W  address of the issued entry.
OutReqData  out  DATA_W  data of the issued entry.
OutReqTag  out  TAG_W  entry index of the issued entry.
CplValid  in  1  read completion returned from the ring.
CplTag  in  TAG_W  entry index of the completed read.
AgeEnAlloc  out  1  allocation strobe to the age matrix.
AgeNextAlloc  out  NUM_ENTRIES  one-hot entry being allocated.
AgeDealloc  out  NUM_ENTRIES  one-hot entry leaving the age order.
AgeMask0  out  NUM_ENTRIES  PEND entries with opcode RD_RSP.
AgeMask1  out  NUM_ENTRIES  PEND entries with opcode RD or WR.
AgeOldest0  in  NUM_ENTRIES  one-hot oldest entry within Mask0 (0 if none).
AgeOldest1  in  NUM_ENTRIES  one-hot oldest entry within Mask1 (0 if none).
Occupancy  out  TAG_W+1  number of non-FREE entries.
ErrCpl  out  1  sticky flag: completion arrived for an entry not in ISSUED.

Behaviour:
- Reset (async assert, sync release): all entries FREE. Outputs: OutReqValid=0, OutReq* payload=0, ErrCpl=0, Occupancy=0, Age* outputs=0. Reset mid-transfer drops every buffered and in-flight request; no completion tracking survives reset.
- Per-entry FSM:
  - FREE -> PEND on allocation.
  - PEND -> ISSUED when loaded into the output register with opcode RD.
  - PEND -> FREE when loaded with opcode WR or RD_RSP (posted).
  - ISSUED -> FREE on CplValid with a matching CplTag.
- Allocation:
  - InReqReady = at least one FREE entry, computed from registered state only.
  - Accept = InReqValid & InReqReady. The lowest-index FREE entry is written with opcode, address and data.
  - Same cycle: AgeEnAlloc=1 and AgeNextAlloc=one-hot of that entry.
  - An illegal opcode is accepted and treated as WR.
- Selection (combinational):
  - If AgeMask0 != 0, select AgeOldest0; else if AgeMask1 != 0, select AgeOldest1; else nothing.
  - Masks are computed from registered state, so a newly allocated entry is eligible from the next cycle.
- Issue register:
  - Loads when (!OutReqValid | OutReqReady) and a selection exists.
  - On load: OutReqValid=1 the next cycle, AgeDealloc=one-hot of the selected entry in the load cycle, entry FSM advances.
  - If OutReqValid & !OutReqReady, all OutReq* hold stable. No selection, no dealloc.
  - If OutReqReady=1 and no selection exists, OutReqValid drops to 0.
- Latency: request accepted at edge t is issued on OutReq at t+2 minimum. Back-to-back issue runs at 1 per cycle under continuous OutReqReady.
- Completion: CplValid with CplTag in ISSUED frees that entry next cycle. A completion for a non-ISSUED tag is ignored and sets ErrCpl (sticky until reset).
- Simultaneous events:
  - A completion or posted issue freeing entry k and an allocation in the same cycle: k is not reusable that cycle, because Ready uses pre-edge state.
  - Alloc and dealloc in the same cycle always target different entries.
- Full: with all NUM_ENTRIES non-FREE, InReqReady=0. Upstream must hold its request.
- Occupancy is updated every cycle as +accept −frees.

Test Plan:
- Reset, single WR at 0x100 with OutReqReady=1 -> OutReqValid exactly at t+2, Tag=0, entry freed on the load cycle, Occupancy returns to 0.
- Allocate RD(A), WR(B), RD_RSP(C) on consecutive cycles with OutReqReady=0, then assert Ready -> issue order C, A, B. Tags A and C are 0 and 2.
- 4 RDs with no completions -> InReqReady=0 and Occupancy=4. CplTag=2 -> InReqReady=1 one cycle later, and the next alloc lands in entry 2.
- OutReqReady held low 5 cycles while valid -> OutReq* stable and AgeDealloc=0 throughout.
- CplValid with a tag in FREE state -> ErrCpl=1 and stays 1, no state change. Async Rst low mid-stream -> all outputs 0 immediately.
- Completion on entry 1 plus InReqValid, with entry 1 the only candidate -> InReqReady=0 that cycle. The request is accepted into entry 1 on the following cycle.

Source files
------------

// File: rtl/rc_req_sched.sv
// Request-buffer scheduler: buffers core requests, drives an external age matrix and
// issues the oldest eligible entry (read responses first) through a registered port.
module rc_req_sched #(
  parameter  int NUM_ENTRIES = 4,
  parameter  int ADDR_W      = 32,
  parameter  int DATA_W      = 32,
  localparam int TAG_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   InReqValid,
  output logic                   InReqReady,
  input  logic [1:0]             InReqOpcode,
  input  logic [ADDR_W-1:0]      InReqAddr,
  input  logic [DATA_W-1:0]      InReqData,
  output logic                   OutReqValid,
  input  logic                   OutReqReady,
  output logic [1:0]             OutReqOpcode,
  output logic [ADDR_W-1:0]      OutReqAddr,
  output logic [DATA_W-1:0]      OutReqData,
  output logic [TAG_W-1:0]       OutReqTag,
  input  logic                   CplValid,
  input  logic [TAG_W-1:0]       CplTag,
  output logic                   AgeEnAlloc,
  output logic [NUM_ENTRIES-1:0] AgeNextAlloc,
  output logic [NUM_ENTRIES-1:0] AgeDealloc,
  output logic [NUM_ENTRIES-1:0] AgeMask0,
  output logic [NUM_ENTRIES-1:0] AgeMask1,
  input  logic [NUM_ENTRIES-1:0] AgeOldest0,
  input  logic [NUM_ENTRIES-1:0] AgeOldest1,
  output logic [TAG_W:0]         Occupancy,
  output logic                   ErrCpl
);

  typedef enum logic [1:0] {ST_FREE, ST_PEND, ST_ISSUED} ent_st_e;

  localparam logic [1:0] OP_RD  = 2'd0;
  localparam logic [1:0] OP_WR  = 2'd1;
  localparam logic [1:0] OP_RSP = 2'd2;

  ent_st_e           st_q   [NUM_ENTRIES];
  logic [1:0]        op_q   [NUM_ENTRIES];
  logic [ADDR_W-1:0] addr_q [NUM_ENTRIES];
  logic [DATA_W-1:0] data_q [NUM_ENTRIES];

  logic              out_valid_q;
  logic [1:0]        out_op_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [DATA_W-1:0] out_data_q;
  logic [TAG_W-1:0]  out_tag_q;
  logic              err_q;
  logic [TAG_W:0]    occ_q, occ_d;

  logic [NUM_ENTRIES-1:0] free_vec, issued_vec, mask0, mask1, sel_oh, alloc_oh;
  logic [TAG_W-1:0]       alloc_idx, sel_idx;
  logic                   accept, load, posted, cpl_hit;
  logic [1:0]             in_op;

  for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_vec
    assign free_vec[gi]   = (st_q[gi] == ST_FREE);
    assign issued_vec[gi] = (st_q[gi] == ST_ISSUED);
    assign mask0[gi]      = (st_q[gi] == ST_PEND) && (op_q[gi] == OP_RSP);
    assign mask1[gi]      = (st_q[gi] == ST_PEND) && (op_q[gi] != OP_RSP);
  end

  assign InReqReady = |free_vec;
  assign accept     = InReqValid & InReqReady;
  assign in_op      = (InReqOpcode == 2'd3) ? OP_WR : InReqOpcode;

  always_comb begin
    alloc_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_idx = TAG_W'(i);
    end
    alloc_oh = '0;
    if (accept) alloc_oh[alloc_idx] = 1'b1;
  end

  // Read responses win outright; the matrix only orders entries within a class.
  always_comb begin
    if (|mask0)      sel_oh = AgeOldest0 & mask0;
    else if (|mask1) sel_oh = AgeOldest1 & mask1;
    else             sel_oh = '0;
    sel_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (sel_oh[i]) sel_idx = sel_idx | TAG_W'(i);
    end
  end

  assign load    = (|sel_oh) & (~out_valid_q | OutReqReady);
  assign posted  = load & (op_q[sel_idx] != OP_RD);
  assign cpl_hit = CplValid & issued_vec[CplTag];
  assign occ_d   = occ_q + (TAG_W+1)'(accept) - (TAG_W+1)'(posted) - (TAG_W+1)'(cpl_hit);

  assign AgeEnAlloc   = accept;
  assign AgeNextAlloc = alloc_oh;
  assign AgeDealloc   = load ? sel_oh : '0;
  assign AgeMask0     = mask0;
  assign AgeMask1     = mask1;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) st_q[i] <= ST_FREE;
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      err_q       <= 1'b0;
      occ_q       <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (alloc_oh[i])                          st_q[i] <= ST_PEND;
        else if (load && sel_oh[i])               st_q[i] <= (op_q[i] == OP_RD) ? ST_ISSUED : ST_FREE;
        else if (cpl_hit && CplTag == TAG_W'(i))  st_q[i] <= ST_FREE;
      end
      if (load) begin
        out_valid_q <= 1'b1;
        out_op_q    <= op_q[sel_idx];
        out_addr_q  <= addr_q[sel_idx];
        out_data_q  <= data_q[sel_idx];
        out_tag_q   <= sel_idx;
      end else if (OutReqReady) begin
        out_valid_q <= 1'b0;
      end
      if (CplValid && !cpl_hit) err_q <= 1'b1;
      occ_q <= occ_d;
    end
  end

  // Payload storage carries no reset; entry state alone decides what is valid.
  always_ff @(posedge Clk) begin
    if (accept) begin
      op_q[alloc_idx]   <= in_op;
      addr_q[alloc_idx] <= InReqAddr;
      data_q[alloc_idx] <= InReqData;
    end
  end

  assign OutReqValid  = out_valid_q;
  assign OutReqOpcode = out_op_q;
  assign OutReqAddr   = out_addr_q;
  assign OutReqData   = out_data_q;
  assign OutReqTag    = out_tag_q;
  assign Occupancy    = occ_q;
  assign ErrCpl       = err_q;

endmodule

// File: tb/tb_rc_req_sched.sv
// Directed bench for rc_req_sched with a behavioural age matrix (oldest = earliest alloc stamp).
module tb_rc_req_sched;

  logic        Clk, Rst;
  logic        InReqValid, InReqReady;
  logic [1:0]  InReqOpcode;
  logic [31:0] InReqAddr, InReqData;
  logic        OutReqValid, OutReqReady;
  logic [1:0]  OutReqOpcode;
  logic [31:0] OutReqAddr, OutReqData;
  logic [1:0]  OutReqTag;
  logic        CplValid;
  logic [1:0]  CplTag;
  logic        AgeEnAlloc;
  logic [3:0]  AgeNextAlloc, AgeDealloc, AgeMask0, AgeMask1, AgeOldest0, AgeOldest1;
  logic [2:0]  Occupancy;
  logic        ErrCpl;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  rc_req_sched #(.NUM_ENTRIES(4), .ADDR_W(32), .DATA_W(32)) dut (
    .Clk(Clk), .Rst(Rst),
    .InReqValid(InReqValid), .InReqReady(InReqReady), .InReqOpcode(InReqOpcode),
    .InReqAddr(InReqAddr), .InReqData(InReqData),
    .OutReqValid(OutReqValid), .OutReqReady(OutReqReady), .OutReqOpcode(OutReqOpcode),
    .OutReqAddr(OutReqAddr), .OutReqData(OutReqData), .OutReqTag(OutReqTag),
    .CplValid(CplValid), .CplTag(CplTag),
    .AgeEnAlloc(AgeEnAlloc), .AgeNextAlloc(AgeNextAlloc), .AgeDealloc(AgeDealloc),
    .AgeMask0(AgeMask0), .AgeMask1(AgeMask1), .AgeOldest0(AgeOldest0), .AgeOldest1(AgeOldest1),
    .Occupancy(Occupancy), .ErrCpl(ErrCpl)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Age matrix model: each allocation stamps its entry; oldest in a mask has the smallest stamp.
  logic [31:0] stamp [4];
  logic [31:0] ctr;

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ctr <= 32'd0;
    end else if (AgeEnAlloc) begin
      ctr <= ctr + 32'd1;
      for (int i = 0; i < 4; i++) if (AgeNextAlloc[i]) stamp[i] <= ctr;
    end
  end

  function automatic logic [3:0] pick(input logic [3:0] m, input logic [31:0] s0, input logic [31:0] s1,
                                      input logic [31:0] s2, input logic [31:0] s3);
    logic [31:0] s [4];
    logic [31:0] best;
    logic [3:0]  res;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    best = 32'hFFFF_FFFF;
    res  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (m[i] && s[i] < best) begin
        best = s[i];
        res  = 4'b0001 << i;
      end
    end
    return res;
  endfunction

  assign AgeOldest0 = pick(AgeMask0, stamp[0], stamp[1], stamp[2], stamp[3]);
  assign AgeOldest1 = pick(AgeMask1, stamp[0], stamp[1], stamp[2], stamp[3]);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
    InReqValid  = 1'b1;
    InReqOpcode = op;
    InReqAddr   = addr;
    InReqData   = data;
  endtask

  initial begin
    Rst = 1'b0; InReqValid = 1'b0; InReqOpcode = 2'd0; InReqAddr = '0; InReqData = '0;
    OutReqReady = 1'b0; CplValid = 1'b0; CplTag = 2'd0;
    #2;
    check("rst_valid", OutReqValid, 0);
    check("rst_occ", Occupancy, 0);
    check("rst_err", ErrCpl, 0);
    check("rst_masks", {AgeMask0, AgeMask1}, 0);
    check("rst_addr", OutReqAddr, 0);
    check("rst_ready", InReqReady, 1);
    repeat (2) @(posedge Clk);
    #3 Rst = 1'b1;
    tick();

    // Single posted write: issued two edges after being presented, freed on its load edge.
    OutReqReady = 1'b1;
    drive(2'd1, 32'h100, 32'hAA); #1;
    check("t1_ready", InReqReady, 1);
    check("t1_en", AgeEnAlloc, 1);
    check("t1_next", AgeNextAlloc, 4'b0001);
    tick(); InReqValid = 1'b0; #1;
    check("t1_valid_early", OutReqValid, 0);
    check("t1_occ1", Occupancy, 1);
    check("t1_dealloc", AgeDealloc, 4'b0001);
    tick();
    check("t1_valid", OutReqValid, 1);
    check("t1_tag", OutReqTag, 0);
    check("t1_addr", OutReqAddr, 32'h100);
    check("t1_data", OutReqData, 32'hAA);
    check("t1_op", OutReqOpcode, 1);
    check("t1_occ0", Occupancy, 0);
    tick();
    check("t1_drop", OutReqValid, 0);

    // Park a write in the stalled output register, then buffer RD A, WR B, RD_RSP C.
    OutReqReady = 1'b0;
    drive(2'd1, 32'hD0, 32'hD);
    tick(); InReqValid = 1'b0; #1;
    check("t2_d_dealloc", AgeDealloc, 4'b0001);
    tick();
    check("t2_d_valid", OutReqValid, 1);
    check("t2_d_occ", Occupancy, 0);
    drive(2'd0, 32'hA0, 32'h1); #1;
    check("t2_a_next", AgeNextAlloc, 4'b0001);
    tick();
    drive(2'd1, 32'hB0, 32'h2); #1;
    check("t2_b_next", AgeNextAlloc, 4'b0010);
    check("t2_b_nodealloc", AgeDealloc, 0);
    tick();
    drive(2'd2, 32'hC0, 32'h3); #1;
    check("t2_c_next", AgeNextAlloc, 4'b0100);
    tick(); InReqValid = 1'b0; #1;
    check("t2_mask0", AgeMask0, 4'b0100);
    check("t2_mask1", AgeMask1, 4'b0011);
    check("t2_occ3", Occupancy, 3);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", OutReqValid, 1);
      check("stall_addr", OutReqAddr, 32'hD0);
      check("stall_op", OutReqOpcode, 1);
      check("stall_dealloc", AgeDealloc, 0);
      tick();
    end
    OutReqReady = 1'b1; #1;
    check("t2_sel_c", AgeDealloc, 4'b0100);
    tick();
    check("iss_c_addr", OutReqAddr, 32'hC0);
    check("iss_c_tag", OutReqTag, 2);
    check("iss_c_op", OutReqOpcode, 2);
    check("iss_c_next", AgeDealloc, 4'b0001);
    tick();
    check("iss_a_addr", OutReqAddr, 32'hA0);
    check("iss_a_tag", OutReqTag, 0);
    check("iss_a_op", OutReqOpcode, 0);
    check("iss_a_next", AgeDealloc, 4'b0010);
    tick();
    check("iss_b_addr", OutReqAddr, 32'hB0);
    check("iss_b_tag", OutReqTag, 1);
    check("iss_b_next", AgeDealloc, 0);
    tick();
    check("t2_idle", OutReqValid, 0);
    check("t2_occ_rd", Occupancy, 1);
    CplValid = 1'b1; CplTag = 2'd0;
    tick(); CplValid = 1'b0;
    check("t2_cpl_occ", Occupancy, 0);
    check("t2_cpl_err", ErrCpl, 0);

    // Completion to a FREE entry is flagged and sticks.
    CplValid = 1'b1; CplTag = 2'd3;
    tick(); CplValid = 1'b0;
    check("err_set", ErrCpl, 1);
    check("err_occ", Occupancy, 0);
    tick(); tick();
    check("err_sticky", ErrCpl, 1);

    // Fill with four reads, then free entry 2 by completion and reuse it.
    for (int i = 0; i < 4; i++) begin
      drive(2'd0, 32'h400 + i, i);
      tick();
    end
    InReqValid = 1'b0; #1;
    check("t3_full_ready", InReqReady, 0);
    check("t3_full_occ", Occupancy, 4);
    tick();
    CplValid = 1'b1; CplTag = 2'd2; #1;
    check("t3_ready_same", InReqReady, 0);
    tick(); CplValid = 1'b0; #1;
    check("t3_ready_next", InReqReady, 1);
    check("t3_occ3", Occupancy, 3);
    drive(2'd0, 32'h500, 32'h5); #1;
    check("t3_reuse2", AgeNextAlloc, 4'b0100);
    tick(); InReqValid = 1'b0;
    check("t3_occ4", Occupancy, 4);
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      CplValid = 1'b1; CplTag = 2'(i);
      tick();
    end
    CplValid = 1'b0; #1;
    check("t3_drain", Occupancy, 0);
    check("t3_err_kept", ErrCpl, 1);

    // Completion on the only candidate entry in the same cycle as a request.
    for (int i = 0; i < 4; i++) begin
      drive(2'd0, 32'h600 + i, i);
      tick();
    end
    InReqValid = 1'b0;
    tick(); tick();
    CplValid = 1'b1; CplTag = 2'd1;
    drive(2'd0, 32'h700, 32'h7); #1;
    check("t5_ready_same", InReqReady, 0);
    check("t5_no_alloc", AgeEnAlloc, 0);
    tick(); CplValid = 1'b0; #1;
    check("t5_ready_next", InReqReady, 1);
    check("t5_into1", AgeNextAlloc, 4'b0010);
    tick(); InReqValid = 1'b0;
    check("t5_occ", Occupancy, 4);
    tick();
    check("pre_rst_valid", OutReqValid, 1);

    // Asynchronous reset mid-stream clears everything at once.
    #2 Rst = 1'b0; #1;
    check("arst_valid", OutReqValid, 0);
    check("arst_occ", Occupancy, 0);
    check("arst_err", ErrCpl, 0);
    check("arst_ready", InReqReady, 1);
    check("arst_masks", {AgeMask0, AgeMask1}, 0);
    check("arst_addr", OutReqAddr, 0);
    check("arst_tag", OutReqTag, 0);
    #3 Rst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
